fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one synchronous FIFO write port among NUM_REQ producers. Each producer presents a valid/ready stream. The arbiter grants one producer at a time for a bounded burst of up to MAX_BURST beats, honours the FIFO full flag in the same cycle, and drives the FIFO's write enable and write data. It sits directly in front of the team's synchronous FIFO, in place of a single producer.

---
 rtl/fifo_arb_pkg.sv | 6 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 110 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int  NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     rr_ptr,
    output logic               found,
    output logic [IDW-1:0]     idx
);

    // Scan offsets from farthest to nearest so the nearest hit is written last and wins.
    always_comb begin
        int          cand;
        logic [IDW-1:0] cidx;
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        cidx  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cidx = IDW'(cand);
            if (req[cidx]) begin
                found = 1'b1;
                idx   = cidx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers,
// with bounded bursts and a same-cycle fifo_full stall.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_WIDTH = 8,
    parameter int  MAX_BURST  = 4,
    localparam int IDW        = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_w_en,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic                          grant_valid,
    output logic [IDW-1:0]                grant_id
);

    localparam int BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    arb_state_e      state, state_nx;
    logic [IDW-1:0]  grant_id_nx;
    logic [IDW-1:0]  rr_ptr, rr_ptr_nx;
    logic [BCW-1:0]  beat_cnt, beat_cnt_nx;
    logic            pick_found;
    logic [IDW-1:0]  pick_idx;
    logic            cur_valid;
    logic [DATA_WIDTH-1:0] cur_data;
    logic            accept;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    always_comb begin
        cur_valid = 1'b0;
        cur_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IDW'(i)) begin
                cur_valid = req_valid[i];
                cur_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A dropped valid releases even while stalled on fifo_full.
    always_comb begin
        state_nx    = state;
        grant_id_nx = grant_id;
        rr_ptr_nx   = rr_ptr;
        beat_cnt_nx = beat_cnt;
        req_ready   = '0;
        accept      = 1'b0;
        fifo_w_en   = 1'b0;
        fifo_data   = cur_data;
        grant_valid = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_id_nx = pick_idx;
                    beat_cnt_nx = '0;
                    state_nx    = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                grant_valid = 1'b1;
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_ready[i] = (grant_id == IDW'(i)) && !fifo_full;
                end
                accept    = cur_valid && !fifo_full;
                fifo_w_en = accept;
                if (accept) begin
                    beat_cnt_nx = beat_cnt + 1'b1;
                end
                if (!cur_valid || (accept && (beat_cnt == BCW'(MAX_BURST - 1)))) begin
                    state_nx    = ARB_IDLE;
                    beat_cnt_nx = '0;
                    rr_ptr_nx   = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                end
            end
            default: begin
                state_nx = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nx;
            grant_id <= grant_id_nx;
            rr_ptr   <= rr_ptr_nx;
            beat_cnt <= beat_cnt_nx;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: queue-driven producers and a per-cycle expectation scoreboard.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_BURST  = 4;

    typedef struct {
        logic       gv;
        logic       we;
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    logic                          clk;
    logic                          rst_n;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_w_en;
    logic [DATA_WIDTH-1:0]         fifo_data;
    logic                          grant_valid;
    logic [1:0]                    grant_id;

    logic [7:0]         pq [NUM_REQ][$];
    exp_t               expq [$];
    logic [NUM_REQ-1:0] acc;
    int                 testsRun;
    int                 failCount;

    fifo_wr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_w_en   (fifo_w_en),
        .fifo_data   (fifo_data),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic void expCycle(logic gv, logic [1:0] id, logic we, logic [7:0] data);
        exp_t e;
        e.gv = gv; e.id = id; e.we = we; e.data = data;
        expq.push_back(e);
    endfunction

    function automatic void expIdle();
        expCycle(1'b0, 2'd0, 1'b0, 8'h00);
    endfunction

    function automatic void expHold(logic [1:0] id);
        expCycle(1'b1, id, 1'b0, 8'h00);
    endfunction

    function automatic void expBurst(logic [1:0] id, logic [7:0] base, int n);
        for (int k = 0; k < n; k++) begin
            expCycle(1'b1, id, 1'b1, base + 8'(k));
        end
    endfunction

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = (pq[i].size() > 0);
            req_data[i*DATA_WIDTH +: DATA_WIDTH] = (pq[i].size() > 0) ? pq[i][0] : 8'h00;
        end
    endtask

    task automatic applyStimulus(input int p, input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            pq[p].push_back(base + 8'(k));
        end
        drive();
    endtask

    // Compare one cycle's outputs against the head of the scoreboard and note accepted beats.
    task automatic checkCycle();
        exp_t       e;
        logic [3:0] rdy;
        if (expq.size() == 0) begin
            testsRun++;
            failCount++;
            $display("[TB] FAIL scoreboard_empty: got no expectation, expected one at %0t", $time);
        end else begin
            e   = expq.pop_front();
            rdy = (e.gv && !fifo_full) ? (4'b0001 << e.id) : 4'b0000;
            checkOutput("grant_valid", 32'(grant_valid), 32'(e.gv));
            checkOutput("req_ready", 32'(req_ready), 32'(rdy));
            checkOutput("fifo_w_en", 32'(fifo_w_en), 32'(e.we));
            if (e.gv) checkOutput("grant_id", 32'(grant_id), 32'(e.id));
            if (e.we) checkOutput("fifo_data", 32'(fifo_data), 32'(e.data));
        end
        acc = req_valid & req_ready;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
        end
        acc = '0;
        drive();
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            checkCycle();
            advance();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        testsRun  = 0;
        failCount = 0;
        rst_n     = 1'b0;
        fifo_full = 1'b0;
        req_valid = '0;
        req_data  = '0;
        acc       = '0;
        #12;
        checkOutput("reset_ready", 32'(req_ready), 32'h0);
        checkOutput("reset_w_en", 32'(fifo_w_en), 32'h0);
        checkOutput("reset_gv", 32'(grant_valid), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All four busy: order 0,1,2,3,0 with one bubble per release.
        applyStimulus(0, 8'h00, 8);
        applyStimulus(1, 8'h10, 4);
        applyStimulus(2, 8'h20, 4);
        applyStimulus(3, 8'h30, 4);
        expIdle();
        expBurst(2'd0, 8'h00, 4); expIdle();
        expBurst(2'd1, 8'h10, 4); expIdle();
        expBurst(2'd2, 8'h20, 4); expIdle();
        expBurst(2'd3, 8'h30, 4); expIdle();
        expBurst(2'd0, 8'h04, 4); expIdle();
        tick(26);

        // Lone producer 2 with six beats splits into 4 + 2.
        applyStimulus(2, 8'h20, 6);
        expIdle();
        expBurst(2'd2, 8'h20, 4); expIdle();
        expBurst(2'd2, 8'h24, 2); expHold(2'd2);
        tick(9);

        // Producer 0 forfeits after one beat; producer 1 follows.
        applyStimulus(0, 8'h40, 1);
        applyStimulus(1, 8'h50, 2);
        expIdle();
        expBurst(2'd0, 8'h40, 1); expHold(2'd0); expIdle();
        expBurst(2'd1, 8'h50, 2); expHold(2'd1);
        tick(7);

        // FIFO full for three cycles mid-burst stalls without releasing.
        applyStimulus(1, 8'h60, 4);
        expIdle();
        expBurst(2'd1, 8'h60, 2);
        expHold(2'd1); expHold(2'd1); expHold(2'd1);
        expBurst(2'd1, 8'h62, 2); expIdle();
        tick(3);
        fifo_full = 1'b1;
        tick(3);
        fifo_full = 1'b0;
        tick(3);

        // Producer 3 release wraps the pointer to 0, so 0 beats 3 next.
        applyStimulus(0, 8'h80, 1);
        applyStimulus(3, 8'h70, 1);
        expIdle();
        expBurst(2'd3, 8'h70, 1); expHold(2'd3); expIdle();
        expBurst(2'd0, 8'h80, 1); expHold(2'd0); expIdle();
        expBurst(2'd3, 8'h71, 1); expHold(2'd3);
        tick(3);
        applyStimulus(3, 8'h71, 1);
        tick(6);

        // Reset mid-burst of producer 2 must clear outputs at once and zero the pointer.
        applyStimulus(1, 8'h90, 4);
        applyStimulus(2, 8'hA0, 2);
        expIdle();
        expBurst(2'd1, 8'h90, 4); expIdle();
        tick(6);
        expBurst(2'd2, 8'hA0, 1);
        @(negedge clk);
        checkCycle();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_ready", 32'(req_ready), 32'h0);
        checkOutput("midrst_w_en", 32'(fifo_w_en), 32'h0);
        checkOutput("midrst_gv", 32'(grant_valid), 32'h0);
        for (int i = 0; i < NUM_REQ; i++) pq[i].delete();
        acc = '0;
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("postrst_gv", 32'(grant_valid), 32'h0);
        applyStimulus(2, 8'hB0, 1);
        applyStimulus(0, 8'hC0, 1);
        expIdle();
        expBurst(2'd0, 8'hC0, 1); expHold(2'd0); expIdle();
        expBurst(2'd2, 8'hB0, 1); expHold(2'd2);
        tick(6);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
